prienc_scan_ctrl: RTL and testbench

Sequential controller for the 8-to-3 priority-encode-and-display datapath. It captures an 8-bit input on request and scans it MSB-first, one bit per clock. It then publishes the encoded index, a valid/sign flag and the matching seven-segment code, signalling completion with a one-cycle done pulse. It sits between the switch inputs and the LED/seven-segment outputs, replacing the purely combinational encode path with a start/busy/done handshake.

---
 rtl/prienc_pkg.sv | 20 ++
 rtl/prienc_seg_lut.sv | 11 +
 rtl/prienc_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_prienc_scan_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prienc_pkg.sv
// Shared types and constants for the priority-encode scan controller.
package prienc_pkg;

    localparam int IDX_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high {a,b,c,d,e,f,g,dp}; element 0 is the rightmost entry.
    localparam logic [7:0][7:0] SEG_LUT = {
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

endpackage

// File: rtl/prienc_seg_lut.sv
// Combinational 3-bit index to active-high seven-segment code.
module prienc_seg_lut
    import prienc_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       seg
);

    assign seg = SEG_LUT[idx];

endmodule

// File: rtl/prienc_scan_ctrl.sv
// MSB-first scanning priority encoder with start/busy/done handshake and 7-seg output.
// Optional periodic self-triggering is enabled by defining PRIENC_AUTO_SAMPLE_EN.
module prienc_scan_ctrl
    import prienc_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              enable,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  ledout,
    output logic              sign,
    output logic [7:0]        segout,
    output state_e            state_dbg
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    ledout_q, ledout_d;
    logic                sign_q, sign_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                auto_req;
    logic                trigger;
    logic [7:0]          seg_raw;

`ifdef PRIENC_AUTO_SAMPLE_EN
    logic [15:0] presc_q, presc_d;

    always_comb begin
        presc_d  = presc_q;
        auto_req = 1'b0;
        if (!enable) begin
            presc_d = '0;
        end else if (presc_q == 16'(DIV - 1)) begin
            presc_d  = '0;
            auto_req = 1'b1;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end
`else
    logic unused_div;
    assign unused_div = ^16'(DIV);
    assign auto_req   = 1'b0;
`endif

    // Requests arriving outside IDLE are dropped, never queued.
    assign trigger = enable && (start || auto_req);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        ledout_d = ledout_q;
        sign_d   = sign_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    shadow_d = data;
                    ptr_d    = IDX_W'(DATA_W - 1);
                    state_d  = SCAN;
                    busy_d   = 1'b1;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (shadow_q[ptr_q]) begin
                    ledout_d = ptr_q;
                    sign_d   = 1'b1;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end else if (ptr_q == '0) begin
                    ledout_d = '0;
                    sign_d   = 1'b0;
                    state_d  = DONE;
                    done_d   = 1'b1;
                end else begin
                    ptr_d  = ptr_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            ptr_q    <= IDX_W'(DATA_W - 1);
            ledout_q <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            ledout_q <= ledout_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    prienc_seg_lut u_seg_lut (
        .idx (ledout_q),
        .seg (seg_raw)
    );

    assign segout    = (enable && sign_q) ? seg_raw : SEG_BLANK;
    assign ledout    = ledout_q;
    assign sign      = sign_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_prienc_scan_ctrl.sv
// Directed bench for prienc_scan_ctrl: vector table plus hand-written corner sequences.
module tb_prienc_scan_ctrl;
    import prienc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       enable;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] ledout;
    logic       sign;
    logic [7:0] segout;
    state_e     state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         lat;
        logic [2:0] idx;
        logic       sgn;
        logic [7:0] seg;
    } vec_t;
    vec_t vecs[8];

    prienc_scan_ctrl #(.DIV(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .enable    (enable),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ledout    (ledout),
        .sign      (sign),
        .segout    (segout),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ledout"}, 32'(ledout), 0);
        check({tag, "_sign"},   32'(sign),   0);
        check({tag, "_done"},   32'(done),   0);
        check({tag, "_busy"},   32'(busy),   0);
        check({tag, "_segout"}, 32'(segout), 0);
        check({tag, "_state"},  32'(state_dbg), 32'(IDLE));
    endtask

    // Samples from cycle cyc0 onward until done; cycle k lies between edge k-1 and edge k.
    task automatic wait_result(input int cyc0, input int lat);
        logic        seen;
        logic [11:0] exp;
        seen = 1'b0;
        exp  = exp_q.pop_front();
        for (int cyc = cyc0; cyc <= 12 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 32'(cyc), 32'(lat));
                check("busy_in_done", 32'(busy), 0);
                check("result", 32'({ledout, sign, segout}), 32'(exp));
            end else begin
                check("busy_scan", 32'(busy), 1);
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within 12 cycles, expected cycle %0d", lat);
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("result_hold", 32'({ledout, sign, segout}), 32'(exp));
    endtask

    task automatic issue_start(input logic [7:0] d, input logic [2:0] idx, input logic sgn,
                               input logic [7:0] seg);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        exp_q.push_back({idx, sgn, seg});
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = 8'($urandom_range(0, 255));
    endtask

    task automatic run_scan(input logic [7:0] d, input int lat, input logic [2:0] idx,
                            input logic sgn, input logic [7:0] seg);
        issue_start(d, idx, sgn, seg);
        wait_result(1, lat);
    endtask

    task automatic count_dones(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{data: 8'h80, lat: 2, idx: 3'd7, sgn: 1'b1, seg: 8'hE0};
        vecs[1] = '{data: 8'h05, lat: 7, idx: 3'd2, sgn: 1'b1, seg: 8'hDA};
        vecs[2] = '{data: 8'h00, lat: 9, idx: 3'd0, sgn: 1'b0, seg: 8'h00};
        vecs[3] = '{data: 8'h01, lat: 9, idx: 3'd0, sgn: 1'b1, seg: 8'hFC};
        vecs[4] = '{data: 8'hFF, lat: 2, idx: 3'd7, sgn: 1'b1, seg: 8'hE0};
        vecs[5] = '{data: 8'h3C, lat: 4, idx: 3'd5, sgn: 1'b1, seg: 8'hB6};
        vecs[6] = '{data: 8'h08, lat: 6, idx: 3'd3, sgn: 1'b1, seg: 8'hF2};
        vecs[7] = '{data: 8'h40, lat: 3, idx: 3'd6, sgn: 1'b1, seg: 8'hBE};

        rst = 1'b1; enable = 1'b0; start = 1'b0; data = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // start with enable low must be ignored
        @(negedge clk);
        enable = 1'b0; start = 1'b1; data = 8'hFF;
        repeat (2) @(negedge clk);
        check("dis_start_state", 32'(state_dbg), 32'(IDLE));
        check("dis_start_busy", 32'(busy), 0);
        start = 1'b0;
        enable = 1'b1;

        // async reset mid-scan after a non-zero result
        run_scan(8'h80, 2, 3'd7, 1'b1, 8'hE0);
        @(negedge clk);
        data = 8'h01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midscan_rst");
        @(negedge clk);
        rst = 1'b0;
        run_scan(8'h80, 2, 3'd7, 1'b1, 8'hE0);

        for (int i = 0; i < 8; i++)
            run_scan(vecs[i].data, vecs[i].lat, vecs[i].idx, vecs[i].sgn, vecs[i].seg);

        // second start during scan is ignored; new data has no effect
        issue_start(8'h10, 3'd4, 1'b1, 8'h66);
        @(negedge clk);
        check("dbl_busy_c1", 32'(busy), 1);
        @(negedge clk);
        check("dbl_busy_c2", 32'(busy), 1);
        data = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(3, 5);
        count_dones(12, cnt);
        check("dbl_no_second_done", 32'(cnt), 0);
        check("dbl_ledout_hold", 32'(ledout), 4);

        // enable drop aborts scan, result and segment blanking
        run_scan(8'h40, 3, 3'd6, 1'b1, 8'hBE);
        @(negedge clk);
        data = 8'h02; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        count_dones(12, cnt);
        check("abort_no_done", 32'(cnt), 0);
        check("abort_ledout", 32'(ledout), 6);
        check("abort_sign", 32'(sign), 1);
        check("abort_seg_blank", 32'(segout), 32'h00);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_busy", 32'(busy), 0);
        enable = 1'b1;
        #1;
        check("abort_seg_restore", 32'(segout), 32'hBE);

`ifdef PRIENC_AUTO_SAMPLE_EN
        begin
            int last_cyc;
            int ndone;
            data = 8'h08;
            start = 1'b0;
            last_cyc = -1;
            ndone = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (done) begin
                    check("auto_ledout", 32'(ledout), 3);
                    check("auto_segout", 32'(segout), 32'hF2);
                    if (last_cyc >= 0) check("auto_period", 32'(c - last_cyc), 16);
                    last_cyc = c;
                    ndone++;
                end
            end
            check("auto_done_count_ok", 32'(ndone >= 4), 1);
        end
`else
        start = 1'b0;
        data = 8'h08;
        count_dones(64, cnt);
        check("no_auto_done", 32'(cnt), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
